gen_w_stream: RTL and testbench
===============================

Name: gen_w_stream

Overview:
Parametrised SHA-2 message-schedule generator. It accepts one padded 16-word block over a valid/ready handshake and streams W[0..ROUNDS-1] one word per cycle over a second valid/ready handshake. It computes each word with a rolling 16-entry window. Supports SHA-256 (WORD_W=32) and SHA-512 (WORD_W=64), with backpressure and abort. It sits between the padder and the compression round engine.

Parameters:
WORD_W, 32, word width; only 32 (SHA-256 sigma functions) or 64 (SHA-512 sigma functions) are legal.
ROUNDS, 64, number of W words emitted per block; use 64 for WORD_W=32 and 80 for WORD_W=64; legal range 16..127.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
blk_valid  in  1  padded block present
blk_ready  out  1  generator can accept a block
blk_data  in  16*WORD_W  block; W[0] in the MSBs, W[15] in the LSBs
w_valid  out  1  w_data/w_index valid
w_ready  in  1  consumer accepts the word
w_data  out  WORD_W  current word W[w_index]
w_index  out  7  index of current word
w_last  out  1  current word is W[ROUNDS-1]
busy  out  1  block in progress
abort  in  1  synchronous abort of the current block

Behaviour:
- States: INIT, IDLE, RUN. Reset forces INIT asynchronously and clears window[0..15], the index counter and the state register.
- INIT: all outputs 0. Moves to IDLE unconditionally on the next clock.
- IDLE: blk_ready=1, w_valid=0, busy=0. When blk_valid&blk_ready: load window[i] <= blk_data word i, index <= 0, go to RUN.
- RUN: blk_ready=0, busy=1, w_valid=1.
  - w_data = window[0] (register output, no combinational path from inputs).
  - w_index = index; w_last = (index==ROUNDS-1).
- Transfer (w_valid&w_ready):
  - window[k] <= window[k+1] for k=0..14.
  - window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], modulo 2^WORD_W.
  - index <= index+1.
- On the transfer with w_last=1: go to IDLE; blk_ready=1 the next cycle. No back-to-back overlap, so minimum block period is ROUNDS+1 cycles.
- Stall (w_valid&~w_ready): window, index, w_data, w_index and w_last hold exactly.
- WORD_W=32:
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10.
- WORD_W=64:
  - sigma0 = ROTR1 ^ ROTR8 ^ SHR7.
  - sigma1 = ROTR19 ^ ROTR61 ^ SHR6.
- Latency: first word is valid the cycle after block acceptance. Throughput is 1 word/cycle with w_ready held high.
- abort=1 in RUN: go to IDLE next cycle and drop any pending transfer (abort has priority over the transfer). abort in INIT/IDLE is ignored; in IDLE a simultaneous blk_valid is still accepted.
- blk_valid while in RUN is ignored (blk_ready=0); the upstream must hold it.
- Async reset mid-RUN: outputs clear immediately and the block is lost.
- Unused window words are don't-care for index >= ROUNDS-16. The counter never wraps, because the RUN exit occurs at ROUNDS-1.

Test Plan:
- SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> words 0..15 echo the block; W16=0x61626380, W17=0x000F0000; exactly 64 transfers; w_last only on index 63; blk_ready=1 the next cycle.
- All-zero block, WORD_W=32 -> 64 words all 0x00000000; busy high for exactly 64 cycles.
- Same "abc" block with w_ready toggled pseudo-randomly -> identical word sequence; w_data/w_index stable across every stall cycle.
- WORD_W=64, ROUNDS=80, block W0=0x6162638000000000, W15=0x18 -> W16=0x6162638000000000, W17=0x00030000000000C0; w_last on index 79.
- abort asserted at index 20 with w_ready=1 -> w_valid=0 the next cycle, no index-20 transfer, blk_ready=1. A new block then restarts at index 0 with correct W.
- reset pulsed mid-RUN at index 37 -> outputs 0 during reset; one INIT cycle; then blk_ready=1; the next block runs fully correctly.

Source files
------------

// File: rtl/gen_w_stream.sv
// rtl/gen_w_stream.sv - SHA-2 message-schedule generator streaming W[0..ROUNDS-1] from a 16-word window
module gen_w_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [16*WORD_W-1:0]  blk_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [WORD_W-1:0]     w_data,
    output logic [6:0]            w_index,
    output logic                  w_last,
    output logic                  busy,
    input  logic                  abort
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RUN
    } state_t;

    // Rotation and shift amounts of the small sigma functions for the selected word width
    localparam int S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int S1_SH = (WORD_W == 64) ? 6  : 10;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_win [16];
    logic [6:0]          r_index;
    logic                w_accept;
    logic                w_xfer;
    logic                w_last_idx;
    logic [WORD_W-1:0]   w_sig0;
    logic [WORD_W-1:0]   w_sig1;
    logic [WORD_W-1:0]   w_new_word;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Next schedule word: window[0] is W[t], so window[1], [9], [14] are W[t+1], W[t+9], W[t+14]
    always_comb begin
        w_sig0     = rotr(r_win[1], S0_R1) ^ rotr(r_win[1], S0_R2) ^ (r_win[1] >> S0_SH);
        w_sig1     = rotr(r_win[14], S1_R1) ^ rotr(r_win[14], S1_R2) ^ (r_win[14] >> S1_SH);
        w_new_word = w_sig1 + r_win[9] + w_sig0 + r_win[0];
    end

    assign w_last_idx = (r_index == 7'(ROUNDS - 1));
    assign w_accept   = (r_state == ST_IDLE) && blk_valid;
    // Abort wins over a pending transfer so the window never advances on the abort cycle
    assign w_xfer     = (r_state == ST_RUN) && w_ready && !abort;

    // Outputs come only from registers; idle states present zeros
    assign w_data  = (r_state == ST_RUN) ? r_win[0] : '0;
    assign w_index = (r_state == ST_RUN) ? r_index : 7'd0;
    assign w_last  = (r_state == ST_RUN) && w_last_idx;

    // Next-state and handshake/status decode
    always_comb begin
        w_state_nxt = r_state;
        blk_ready   = 1'b0;
        w_valid     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_valid = 1'b1;
                busy    = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ready && w_last_idx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rolling window and word index: load on accept, shift in the new word on each transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
            r_index <= 7'd0;
        end else if (w_accept) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= blk_data[(15 - i) * WORD_W +: WORD_W];
            end
            r_index <= 7'd0;
        end else if (w_xfer) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i + 1];
            end
            r_win[15] <= w_new_word;
            r_index   <= r_index + 7'd1;
        end
    end

endmodule

// File: tb/tb_gen_w_stream.sv
// tb/tb_gen_w_stream.sv - scoreboard bench for gen_w_stream at SHA-256 and SHA-512 widths
module tb_gen_w_stream;

    logic          clock;
    logic          tb_reset;
    logic          tb_blk_valid;
    logic          tb_w_ready;
    logic          tb_abort;
    logic [511:0]  tb_blk32;
    logic [1023:0] tb_blk64;
    int            sel;

    logic          blk_valid32, blk_ready32, w_valid32, w_last32, busy32, abort32;
    logic [31:0]   w_data32;
    logic [6:0]    w_index32;
    logic          blk_valid64, blk_ready64, w_valid64, w_last64, busy64, abort64;
    logic [63:0]   w_data64;
    logic [6:0]    w_index64;

    logic          m_valid, m_bready, m_last, m_busy;
    logic [63:0]   m_data;
    logic [6:0]    m_idx;

    int            n_vec;
    int            n_err;
    logic [63:0]   sb_q[$];
    logic [63:0]   blk_w [16];
    logic [63:0]   exp_w [80];
    int            busy_cyc;

    assign blk_valid32 = tb_blk_valid && (sel == 0);
    assign blk_valid64 = tb_blk_valid && (sel == 1);
    assign abort32     = tb_abort && (sel == 0);
    assign abort64     = tb_abort && (sel == 1);

    assign m_valid  = (sel == 1) ? w_valid64   : w_valid32;
    assign m_bready = (sel == 1) ? blk_ready64 : blk_ready32;
    assign m_last   = (sel == 1) ? w_last64    : w_last32;
    assign m_busy   = (sel == 1) ? busy64      : busy32;
    assign m_data   = (sel == 1) ? w_data64    : {32'd0, w_data32};
    assign m_idx    = (sel == 1) ? w_index64   : w_index32;

    gen_w_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
        .clock     (clock),
        .reset     (tb_reset),
        .blk_valid (blk_valid32),
        .blk_ready (blk_ready32),
        .blk_data  (tb_blk32),
        .w_valid   (w_valid32),
        .w_ready   (tb_w_ready),
        .w_data    (w_data32),
        .w_index   (w_index32),
        .w_last    (w_last32),
        .busy      (busy32),
        .abort     (abort32)
    );

    gen_w_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .clock     (clock),
        .reset     (tb_reset),
        .blk_valid (blk_valid64),
        .blk_ready (blk_ready64),
        .blk_data  (tb_blk64),
        .w_valid   (w_valid64),
        .w_ready   (tb_w_ready),
        .w_data    (w_data64),
        .w_index   (w_index64),
        .w_last    (w_last64),
        .busy      (busy64),
        .abort     (abort64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Textbook full-array expansion, independent of the rolling window
    task automatic build_model(input int use64, input int rounds);
        logic [31:0] a32, b32;
        logic [63:0] a64, b64;
        for (int t = 0; t < 16; t++) begin
            exp_w[t] = use64 ? blk_w[t] : {32'd0, blk_w[t][31:0]};
        end
        for (int t = 16; t < rounds; t++) begin
            if (use64) begin
                a64 = rotr64(exp_w[t-15], 1) ^ rotr64(exp_w[t-15], 8) ^ (exp_w[t-15] >> 7);
                b64 = rotr64(exp_w[t-2], 19) ^ rotr64(exp_w[t-2], 61) ^ (exp_w[t-2] >> 6);
                exp_w[t] = b64 + exp_w[t-7] + a64 + exp_w[t-16];
            end else begin
                a32 = rotr32(exp_w[t-15][31:0], 7) ^ rotr32(exp_w[t-15][31:0], 18) ^ (exp_w[t-15][31:0] >> 3);
                b32 = rotr32(exp_w[t-2][31:0], 17) ^ rotr32(exp_w[t-2][31:0], 19) ^ (exp_w[t-2][31:0] >> 10);
                exp_w[t] = {32'd0, b32 + exp_w[t-7][31:0] + a32 + exp_w[t-16][31:0]};
            end
        end
    endtask

    task automatic set_block(input logic [63:0] w0, input logic [63:0] w15);
        for (int i = 0; i < 16; i++) blk_w[i] = 64'd0;
        blk_w[0]  = w0;
        blk_w[15] = w15;
    endtask

    task automatic run_block(input int use64, input int rnd, input int abort_at, input int reset_at,
                             input int abort_on_accept, input int chk_const,
                             input logic [63:0] e16, input logic [63:0] e17, output int bcyc);
        int rounds;
        int idx;
        int cyc;
        rounds = use64 ? 80 : 64;
        sel    = use64;
        bcyc   = 0;
        build_model(use64, rounds);
        for (int i = 0; i < 16; i++) begin
            tb_blk32[(15 - i) * 32 +: 32] = blk_w[i][31:0];
            tb_blk64[(15 - i) * 64 +: 64] = blk_w[i];
        end
        for (int t = 0; t < rounds; t++) sb_q.push_back(exp_w[t]);

        @(negedge clock);
        chk("idle_blk_ready", {63'd0, m_bready}, 64'd1);
        chk("idle_w_valid", {63'd0, m_valid}, 64'd0);
        tb_blk_valid = 1'b1;
        tb_abort     = (abort_on_accept != 0);
        @(negedge clock);
        tb_blk_valid = 1'b0;
        tb_abort     = 1'b0;

        idx = 0;
        cyc = 0;
        while (idx < rounds && cyc < 1000) begin
            if (m_busy) bcyc++;
            chk("run_w_valid", {63'd0, m_valid}, 64'd1);
            chk("run_busy", {63'd0, m_busy}, 64'd1);
            chk("run_blk_ready", {63'd0, m_bready}, 64'd0);
            chk("w_index", {57'd0, m_idx}, 64'(idx));
            chk("w_data", m_data, sb_q[0]);
            chk("w_last", {63'd0, m_last}, {63'd0, idx == rounds - 1});
            if (chk_const != 0 && idx == 16) chk("W16_const", m_data, e16);
            if (chk_const != 0 && idx == 17) chk("W17_const", m_data, e17);
            if (idx == abort_at) begin
                tb_abort   = 1'b1;
                tb_w_ready = 1'b1;
                @(negedge clock);
                tb_abort = 1'b0;
                chk("abort_w_valid", {63'd0, m_valid}, 64'd0);
                chk("abort_blk_ready", {63'd0, m_bready}, 64'd1);
                chk("abort_busy", {63'd0, m_busy}, 64'd0);
                sb_q.delete();
                return;
            end
            if (idx == reset_at) begin
                tb_reset = 1'b1;
                #1;
                chk("rst_w_valid", {63'd0, m_valid}, 64'd0);
                chk("rst_busy", {63'd0, m_busy}, 64'd0);
                chk("rst_blk_ready", {63'd0, m_bready}, 64'd0);
                chk("rst_w_data", m_data, 64'd0);
                chk("rst_w_index", {57'd0, m_idx}, 64'd0);
                @(negedge clock);
                tb_reset = 1'b0;
                #1;
                chk("init_blk_ready", {63'd0, m_bready}, 64'd0);
                chk("init_w_valid", {63'd0, m_valid}, 64'd0);
                @(negedge clock);
                chk("post_init_blk_ready", {63'd0, m_bready}, 64'd1);
                sb_q.delete();
                return;
            end
            tb_w_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tb_w_ready) begin
                void'(sb_q.pop_front());
                idx++;
            end
            @(negedge clock);
            cyc++;
        end
        tb_w_ready = 1'b1;
        chk("no_timeout", {63'd0, cyc < 1000}, 64'd1);
        chk("done_w_valid", {63'd0, m_valid}, 64'd0);
        chk("done_blk_ready", {63'd0, m_bready}, 64'd1);
        chk("done_busy", {63'd0, m_busy}, 64'd0);
        chk("queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        sel          = 0;
        tb_reset     = 1'b1;
        tb_blk_valid = 1'b0;
        tb_w_ready   = 1'b1;
        tb_abort     = 1'b0;
        tb_blk32     = '0;
        tb_blk64     = '0;

        #12;
        chk("reset_blk_ready", {63'd0, m_bready}, 64'd0);
        chk("reset_w_valid", {63'd0, m_valid}, 64'd0);
        chk("reset_busy", {63'd0, m_busy}, 64'd0);
        chk("reset_w_data", m_data, 64'd0);
        @(negedge clock);
        tb_reset = 1'b0;
        #1;
        chk("first_init_blk_ready", {63'd0, m_bready}, 64'd0);

        // "abc" SHA-256 block, full throughput
        set_block(64'h61626380, 64'h18);
        run_block(0, 0, -1, -1, 0, 1, 64'h61626380, 64'h000F0000, busy_cyc);

        // All-zero block
        set_block(64'h0, 64'h0);
        run_block(0, 0, -1, -1, 0, 1, 64'h0, 64'h0, busy_cyc);
        chk("zero_busy_cycles", 64'(busy_cyc), 64'd64);

        // "abc" with random backpressure
        set_block(64'h61626380, 64'h18);
        run_block(0, 1, -1, -1, 0, 1, 64'h61626380, 64'h000F0000, busy_cyc);

        // SHA-512 width, 80 rounds, with random backpressure
        set_block(64'h6162638000000000, 64'h18);
        run_block(1, 0, -1, -1, 0, 1, 64'h6162638000000000, 64'h00030000000000C0, busy_cyc);
        chk("w64_busy_cycles", 64'(busy_cyc), 64'd80);
        run_block(1, 1, -1, -1, 0, 1, 64'h6162638000000000, 64'h00030000000000C0, busy_cyc);

        // Abort at index 20, then restart with abort held during acceptance
        set_block(64'h61626380, 64'h18);
        run_block(0, 0, 20, -1, 0, 0, 64'h0, 64'h0, busy_cyc);
        run_block(0, 0, -1, -1, 1, 1, 64'h61626380, 64'h000F0000, busy_cyc);

        // Reset pulse mid-run at index 37, then a clean block
        run_block(0, 0, -1, 37, 0, 0, 64'h0, 64'h0, busy_cyc);
        run_block(0, 0, -1, -1, 0, 1, 64'h61626380, 64'h000F0000, busy_cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
